// File: rtl/mfp_serial_spi.sv
// SPI target (mode 0, MSB first) bridging the IO controller to the MFP serial FIFOs.
// SPI pins are oversampled in the clk domain; command byte selects status read, pop, push or status set.
module mfp_serial_spi (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        serial_data_out_available,
  input  logic [7:0]  serial_data_out,
  output logic        serial_strobe_out,
  input  logic [63:0] serial_status_out,
  input  logic        serial_data_in_full,
  output logic [7:0]  serial_data_in,
  output logic        serial_strobe_in,
  output logic [7:0]  serial_status_in
);

  typedef enum logic [2:0] {
    S_CMD, S_STATUS, S_RD_FLAG, S_RD_DATA, S_RD_DONE, S_WRITE, S_SETSTAT, S_IGNORE
  } state_t;

  state_t      state_reg, state_next;
  logic        sck_s1, sck_s2, sck_d;
  logic        ss_s1, ss_s2;
  logic        mosi_s1, mosi_s2;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_shift_reg;
  logic [7:0]  tx_shift_reg;
  logic [63:0] stat_q_reg;
  logic [3:0]  idx_reg;
  logic        rd_avail_reg;
  logic [7:0]  rd_byte_reg;
  logic        ign_ff_reg;
  logic        armed_reg;
  logic        strobe_out_reg, strobe_in_reg;
  logic [7:0]  data_in_reg, status_in_reg;

  logic        ss_active, sck_rise, sck_fall, byte_done;
  logic [7:0]  rx_byte;
  logic [63:0] stat_shift;
  logic [7:0]  resp_byte;
  logic        pop_next, push_next, write_cap, set_status, snap_load, rd_latch;

  // Synchronisers are left unreset so that SS held low across a reset is still seen as low.
  always_ff @(posedge clk) begin
    sck_s1  <= spi_sck;
    sck_s2  <= sck_s1;
    sck_d   <= sck_s2;
    ss_s1   <= spi_ss_n;
    ss_s2   <= ss_s1;
    mosi_s1 <= spi_mosi;
    mosi_s2 <= mosi_s1;
  end

  assign ss_active  = ~ss_s2;
  assign sck_rise   = sck_s2 & ~sck_d;
  assign sck_fall   = ~sck_s2 & sck_d;
  assign rx_byte    = {rx_shift_reg[6:0], mosi_s2};
  assign byte_done  = ss_active & armed_reg & sck_rise & (bit_cnt_reg == 3'd7);
  assign stat_shift = stat_q_reg << {idx_reg[2:0], 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_CMD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!ss_active) begin
      state_next = S_CMD;
    end else if (byte_done) begin
      case (state_reg)
        S_CMD: begin
          case (rx_byte)
            8'h50:   state_next = S_STATUS;
            8'h51:   state_next = S_RD_FLAG;
            8'h52:   state_next = S_WRITE;
            8'h53:   state_next = S_SETSTAT;
            default: state_next = S_IGNORE;
          endcase
        end
        S_RD_FLAG: state_next = S_RD_DATA;
        S_RD_DATA: state_next = S_RD_DONE;
        S_SETSTAT: state_next = S_IGNORE;
        default:   state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    resp_byte  = 8'h00;
    pop_next   = 1'b0;
    push_next  = 1'b0;
    write_cap  = 1'b0;
    set_status = 1'b0;
    snap_load  = 1'b0;
    rd_latch   = 1'b0;
    if (byte_done) begin
      case (state_reg)
        S_CMD: begin
          case (rx_byte)
            8'h50: begin
              snap_load = 1'b1;
              resp_byte = serial_status_out[63:56];
            end
            8'h51: begin
              rd_latch  = 1'b1;
              resp_byte = {7'b0, serial_data_out_available};
            end
            8'h52, 8'h53: resp_byte = 8'h00;
            default:      resp_byte = 8'hFF;
          endcase
        end
        S_STATUS:  resp_byte = idx_reg[3] ? 8'h00 : stat_shift[63:56];
        S_RD_FLAG: resp_byte = rd_avail_reg ? rd_byte_reg : 8'h00;
        S_RD_DATA: pop_next  = rd_avail_reg;
        S_WRITE: begin
          write_cap = 1'b1;
          push_next = ~serial_data_in_full;
        end
        S_SETSTAT: set_status = 1'b1;
        S_IGNORE:  resp_byte  = ign_ff_reg ? 8'hFF : 8'h00;
        default:   resp_byte  = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg    <= 3'd0;
      rx_shift_reg   <= 8'h00;
      tx_shift_reg   <= 8'h00;
      stat_q_reg     <= 64'h0;
      idx_reg        <= 4'd0;
      rd_avail_reg   <= 1'b0;
      rd_byte_reg    <= 8'h00;
      ign_ff_reg     <= 1'b0;
      armed_reg      <= 1'b0;
      strobe_out_reg <= 1'b0;
      strobe_in_reg  <= 1'b0;
      data_in_reg    <= 8'h00;
      status_in_reg  <= 8'h00;
    end else begin
      strobe_out_reg <= pop_next;
      strobe_in_reg  <= push_next;
      // After a reset the bit counter stays parked until SS is seen high, so a cut-off transaction cannot misalign bytes.
      if (!ss_active) begin
        bit_cnt_reg  <= 3'd0;
        tx_shift_reg <= 8'h00;
        armed_reg    <= 1'b1;
      end else if (!armed_reg) begin
        bit_cnt_reg  <= 3'd0;
      end else begin
        if (sck_rise) begin
          rx_shift_reg <= rx_byte;
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        end
        if (byte_done) begin
          tx_shift_reg <= resp_byte;
        end else if (sck_fall && bit_cnt_reg != 3'd0) begin
          tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
        end
      end
      if (snap_load) begin
        stat_q_reg <= serial_status_out;
        idx_reg    <= 4'd1;
      end else if (byte_done && state_reg == S_STATUS && !idx_reg[3]) begin
        idx_reg    <= idx_reg + 4'd1;
      end
      if (byte_done && state_reg == S_CMD) begin
        ign_ff_reg <= (state_next == S_IGNORE);
      end
      if (rd_latch) begin
        rd_avail_reg <= serial_data_out_available;
        rd_byte_reg  <= serial_data_out;
      end
      if (write_cap) begin
        data_in_reg <= rx_byte;
      end
      if (set_status) begin
        status_in_reg <= rx_byte;
      end
    end
  end

  assign spi_miso          = tx_shift_reg[7];
  assign serial_strobe_out = strobe_out_reg;
  assign serial_strobe_in  = strobe_in_reg;
  assign serial_data_in    = data_in_reg;
  assign serial_status_in  = status_in_reg;

endmodule

// File: tb/tb_mfp_serial_spi.sv
// Directed bench for mfp_serial_spi: SPI master model with a MISO scoreboard and a strobe monitor.
module tb_mfp_serial_spi;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sck, spi_ss_n, spi_mosi, spi_miso;
  logic        serial_data_out_available;
  logic [7:0]  serial_data_out;
  logic        serial_strobe_out;
  logic [63:0] serial_status_out;
  logic        serial_data_in_full;
  logic [7:0]  serial_data_in;
  logic        serial_strobe_in;
  logic [7:0]  serial_status_in;

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int miso_sb[$];
  logic [7:0] push_sb[$];
  logic [7:0] rxb;
  logic [7:0] st_exp [9] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};

  mfp_serial_spi dut (
    .clk                       (clk),
    .reset                     (reset),
    .spi_sck                   (spi_sck),
    .spi_ss_n                  (spi_ss_n),
    .spi_mosi                  (spi_mosi),
    .spi_miso                  (spi_miso),
    .serial_data_out_available (serial_data_out_available),
    .serial_data_out           (serial_data_out),
    .serial_strobe_out         (serial_strobe_out),
    .serial_status_out         (serial_status_out),
    .serial_data_in_full       (serial_data_in_full),
    .serial_data_in            (serial_data_in),
    .serial_strobe_in          (serial_strobe_in),
    .serial_status_in          (serial_status_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SCK half period is 8 clk cycles; MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (8) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // exp < 0 marks a byte whose MISO content is not checked.
  task automatic send(input logic [7:0] tx, input int exp);
    int e;
    logic [7:0] rx;
    miso_sb.push_back(exp);
    xfer(tx, 8, rx);
    e = miso_sb.pop_front();
    $display("spi tx %02h rx %02h", tx, rx);
    if (e >= 0) chk("miso_byte", {56'h0, rx}, {56'h0, e[7:0]});
  endtask

  task automatic ss_low();
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (8) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (serial_strobe_out || serial_strobe_in) begin
        vectors++;
        miscompares++;
        $error("FAIL strobe_in_reset observed %b%b expected 00", serial_strobe_out, serial_strobe_in);
      end
    end else begin
      if (serial_strobe_out) begin
        pop_cnt++;
        $display("pop strobe, data %02h", serial_data_out);
      end
      if (serial_strobe_in) begin
        push_cnt++;
        $display("push strobe, data %02h", serial_data_in);
        if (push_sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL push_unexpected observed %0h expected no strobe", serial_data_in);
        end else begin
          chk("push_data", {56'h0, serial_data_in}, {56'h0, push_sb.pop_front()});
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    spi_sck = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    serial_data_out_available = 1'b0;
    serial_data_out = 8'h00;
    serial_status_out = 64'h0;
    serial_data_in_full = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_miso", {63'h0, spi_miso}, 64'h0);
    chk("rst_strobe_out", {63'h0, serial_strobe_out}, 64'h0);
    chk("rst_strobe_in", {63'h0, serial_strobe_in}, 64'h0);
    chk("rst_data_in", {56'h0, serial_data_in}, 64'h0);
    chk("rst_status_in", {56'h0, serial_status_in}, 64'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Status read; the input changes mid-transfer but the snapshot must hold.
    serial_status_out = 64'h0123456789ABCDEF;
    ss_low();
    send(8'h50, -1);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) serial_status_out = 64'hFEDCBA9876543210;
      send(8'h00, int'(st_exp[i]));
    end
    ss_high();
    chk("miso_idle", {63'h0, spi_miso}, 64'h0);

    // Pop with data available.
    serial_data_out_available = 1'b1;
    serial_data_out = 8'h5A;
    ss_low();
    send(8'h51, -1);
    send(8'h00, 8'h01);
    chk("pop_not_early", pop_cnt, 0);
    send(8'h00, 8'h5A);
    chk("pop_after_byte3", pop_cnt, 1);
    send(8'h00, 8'h00);
    ss_high();
    chk("pop_once", pop_cnt, 1);

    // Pop with FIFO empty.
    serial_data_out_available = 1'b0;
    serial_data_out = 8'h99;
    ss_low();
    send(8'h51, -1);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    ss_high();
    chk("pop_empty", pop_cnt, 1);

    // Push with backpressure on the middle byte.
    ss_low();
    send(8'h52, -1);
    push_sb.push_back(8'h11);
    send(8'h11, 8'h00);
    serial_data_in_full = 1'b1;
    send(8'h22, 8'h00);
    serial_data_in_full = 1'b0;
    push_sb.push_back(8'h33);
    send(8'h33, 8'h00);
    ss_high();
    chk("push_count", push_cnt, 2);
    chk("push_pending", push_sb.size(), 0);
    chk("data_in_last", {56'h0, serial_data_in}, 64'h33);

    // Status set, then an unknown command.
    ss_low();
    send(8'h53, -1);
    send(8'hC3, 8'h00);
    ss_high();
    chk("status_in", {56'h0, serial_status_in}, 64'hC3);
    ss_low();
    send(8'h7E, -1);
    send(8'h00, 8'hFF);
    ss_high();
    chk("ignore_pops", pop_cnt, 1);
    chk("ignore_pushes", push_cnt, 2);

    // Abort a pop half way through its second byte, then pop again cleanly.
    serial_data_out_available = 1'b1;
    serial_data_out = 8'h5A;
    ss_low();
    send(8'h51, -1);
    xfer(8'h00, 4, rxb);
    ss_high();
    chk("abort_no_pop", pop_cnt, 1);
    ss_low();
    send(8'h51, -1);
    send(8'h00, 8'h01);
    send(8'h00, 8'h5A);
    send(8'h00, 8'h00);
    ss_high();
    chk("pop_after_abort", pop_cnt, 2);
    serial_data_out_available = 1'b0;

    // Reset in the middle of a write; later bytes with SS still low must be ignored.
    ss_low();
    send(8'h52, -1);
    xfer(8'h44, 4, rxb);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_miso", {63'h0, spi_miso}, 64'h0);
    chk("midrst_data_in", {56'h0, serial_data_in}, 64'h0);
    chk("midrst_status_in", {56'h0, serial_status_in}, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    xfer(8'h40, 4, rxb);
    xfer(8'h55, 8, rxb);
    ss_high();
    chk("midrst_no_push", push_cnt, 2);
    chk("midrst_data_hold", {56'h0, serial_data_in}, 64'h0);

    // Normal write after recovery.
    ss_low();
    send(8'h52, -1);
    push_sb.push_back(8'h66);
    send(8'h66, 8'h00);
    ss_high();
    chk("recover_push", push_cnt, 3);
    chk("recover_data", {56'h0, serial_data_in}, 64'h66);
    chk("total_pops", pop_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
